// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and constants for the byte-serial memory controller.
// Width codes, FSM state encodings and word/address length constants live here.
package mem_ctrl_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int REQ_ADDR_W = 32;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WIDTH_BYTE     = 2'b00,
    WIDTH_HALF     = 2'b01,
    WIDTH_WORD     = 2'b10,
    WIDTH_WORD_ALT = 2'b11
  } width_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_LAST = 3'd2,
    S_WR      = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  // Index of the final byte of an access: 0, 1 or 3.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 2'd0;
      WIDTH_HALF: return 2'd1;
      default:    return 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lsb);
    case (width)
      WIDTH_BYTE: return 1'b0;
      WIDTH_HALF: return lsb[0];
      default:    return lsb != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load-data extension: sign- or zero-extends the assembled byte/half, words pass through.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] raw,
  input  logic [1:0]        width,
  input  logic              sign,
  output logic [WORD_W-1:0] ext
);

  logic signed [BYTE_W-1:0]   raw_byte;
  logic signed [2*BYTE_W-1:0] raw_half;

  assign raw_byte = raw[BYTE_W-1:0];
  assign raw_half = raw[2*BYTE_W-1:0];

  always_comb begin
    ext = raw;
    case (width)
      WIDTH_BYTE: ext = sign ? WORD_W'(raw_byte) : WORD_W'($unsigned(raw_byte));
      WIDTH_HALF: ext = sign ? WORD_W'(raw_half) : WORD_W'($unsigned(raw_half));
      default:    ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller between a MEM stage and an 8-bit synchronous RAM.
// Define MEM_CTRL_MISALIGN_CHK_EN to reject misaligned half/word accesses with resp_err.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        rcnt_q;
  logic [1:0]        last_q;
  logic [1:0]        width_q;
  logic              sign_q;
  logic              accept;
  logic              misalign;
  logic              sample_en;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] raw_q;
  logic [WORD_W-1:0] raw_d;
  logic [WORD_W-1:0] ext_data;

  assign accept = req_valid && req_ready;

`ifdef MEM_CTRL_MISALIGN_CHK_EN
  logic err_q;

  assign misalign = is_misaligned(req_width, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign resp_err = resp_valid & err_q;
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    ram_wr     = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misalign)    state_d = S_RESP;
          else if (req_we) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == last_q) state_d = S_RD_LAST;
      end
      S_RD_LAST: state_d = S_RESP;
      S_WR: begin
        ram_wr = 1'b1;
        if (cnt_q == last_q) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM returns byte k one cycle after its address, so sampling lags issue by one cycle.
  assign sample_en = ((state_q == S_RD) && (cnt_q != 2'd0)) || (state_q == S_RD_LAST);

  always_comb begin
    raw_d = raw_q;
    case (rcnt_q)
      2'd0: raw_d[7:0]   = ram_din;
      2'd1: raw_d[15:8]  = ram_din;
      2'd2: raw_d[23:16] = ram_din;
      default: raw_d[31:24] = ram_din;
    endcase
  end

  load_ext u_load_ext (
    .raw   (raw_d),
    .width (width_q),
    .sign  (sign_q),
    .ext   (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 2'd0;
      rcnt_q     <= 2'd0;
      resp_rdata <= ZERO_WORD;
      ram_addr   <= '0;
      ram_dout   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q  <= 2'd0;
            rcnt_q <= 2'd0;
            if (misalign) begin
              resp_rdata <= ZERO_WORD;
            end else begin
              ram_addr <= req_addr[ADDR_W-1:0];
              if (req_we) ram_dout <= req_wdata[7:0];
            end
          end
        end
        S_RD: begin
          if (cnt_q != last_q) begin
            cnt_q    <= cnt_q + 2'd1;
            ram_addr <= ram_addr + ADDR_W'(1);
          end
          if (cnt_q != 2'd0) rcnt_q <= rcnt_q + 2'd1;
        end
        S_RD_LAST: resp_rdata <= ext_data;
        S_WR: begin
          if (cnt_q != last_q) begin
            cnt_q    <= cnt_q + 2'd1;
            ram_addr <= ram_addr + ADDR_W'(1);
            ram_dout <= wdata_q[15:8];
          end else begin
            resp_rdata <= ZERO_WORD;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields and byte assembly are data only; they are always reloaded at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      width_q <= req_width;
      sign_q  <= req_sign;
      last_q  <= last_byte_idx(req_width);
      wdata_q <= req_wdata;
      raw_q   <= ZERO_WORD;
    end else begin
      if (sample_en) raw_q <= raw_d;
      if (state_q == S_WR) wdata_q <= wdata_q >> BYTE_W;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM emulator plus a flat-array reference model.
// Honours MEM_CTRL_MISALIGN_CHK_EN when computing expected responses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  int total = 0;
  int bad   = 0;

`ifdef MEM_CTRL_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_width  (req_width),
    .req_sign   (req_sign),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wr     (ram_wr),
    .ram_dout   (ram_dout),
    .ram_din    (ram_din)
  );

  // RAM emulator: 512-byte window, addresses alias on their low 9 bits.
  logic [7:0] ram [0:511];
  bit         wrote [0:511];
  logic [7:0] ref_mem [0:511];

  function automatic logic [7:0] init_byte(input logic [8:0] a);
    logic [31:0] v;
    v = (32'(a) * 32'd37 + 32'd11) ^ (32'(a) >> 3);
    return v[7:0];
  endfunction

  function automatic logic [7:0] ram_val(input logic [8:0] a);
    return wrote[a] ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (ram_wr) begin
      ram[ram_addr[8:0]]   <= ram_dout;
      wrote[ram_addr[8:0]] <= 1'b1;
    end
    ram_din <= ram_val(ram_addr[8:0]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request starting at a negedge; returns at the negedge of the first idle cycle.
  task automatic run_req(input bit we, input logic [31:0] addr, input logic [1:0] width,
                         input bit sign, input logic [31:0] wdata);
    int          n;
    int          resp_cyc;
    bit          mis;
    logic [31:0] exp_data;
    logic [31:0] a;
    logic [31:0] prev_addr;
    logic [31:0] last_addr;
    logic [31:0] sh;
    n   = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    mis = CHK_EN && ((width == 2'b01 && addr[0]) || (width[1] && addr[1:0] != 2'b00));
    resp_cyc = mis ? 1 : (we ? n + 1 : n + 2);
    exp_data = 32'h0;
    if (!mis && !we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        exp_data = exp_data | (32'(ref_mem[a[8:0]]) << (8 * k));
      end
      if (sign && n < 4 && exp_data[8*n-1])
        exp_data = exp_data | ~((32'h1 << (8 * n)) - 32'h1);
    end
    if (!mis && we) begin
      for (int k = 0; k < n; k++) begin
        a  = addr + 32'(k);
        sh = wdata >> (8 * k);
        ref_mem[a[8:0]] = sh[7:0];
      end
    end
    prev_addr = ram_addr;
    last_addr = mis ? prev_addr : addr + 32'(n - 1);

    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_width = width;
    req_sign  = sign;
    req_wdata = wdata;
    @(posedge clk);
    for (int c = 1; c <= resp_cyc + 1; c++) begin
      @(negedge clk);
      chk("ram_wr", 32'(ram_wr), 32'(we && !mis && c <= n));
      if (!mis && c <= n) chk("ram_addr", ram_addr, addr + 32'(c - 1));
      if (mis && c == 1) chk("mis_addr_hold", ram_addr, prev_addr);
      if (we && !mis && c <= n) begin
        sh = wdata >> (8 * (c - 1));
        chk("ram_dout", 32'(ram_dout), 32'(sh[7:0]));
      end
      chk("resp_valid", 32'(resp_valid), 32'(c == resp_cyc));
      if (c == resp_cyc) begin
        chk("rdata", resp_rdata, exp_data);
        chk("err", 32'(resp_err), 32'(mis));
      end
      if (c <= resp_cyc) begin
        chk("ready_busy", 32'(req_ready), 32'd0);
      end else begin
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("rdata_held", resp_rdata, exp_data);
        chk("addr_idle", ram_addr, last_addr);
      end
      if (c == 1) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_width = 2'($urandom);
        req_sign  = 1'($urandom);
        req_wdata = $urandom;
      end
    end
    if (we) begin
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        chk("ram_byte", 32'(ram_val(a[8:0])), 32'(ref_mem[a[8:0]]));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(9'(i));
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'h0;
    req_width = 2'b00;
    req_sign  = 1'b0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    rst = 1'b1;

    // Preload through the controller, then the documented scenarios.
    run_req(1'b1, 32'h100, 2'b10, 1'b0, 32'h44332211);
    run_req(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    chk("word_load_0x100", resp_rdata, 32'h44332211);
    run_req(1'b1, 32'h20, 2'b00, 1'b0, 32'h12345680);
    run_req(1'b0, 32'h20, 2'b00, 1'b1, 32'h0);
    chk("byte_sext", resp_rdata, 32'hFFFFFF80);
    run_req(1'b0, 32'h20, 2'b00, 1'b0, 32'h0);
    chk("byte_zext", resp_rdata, 32'h00000080);
    run_req(1'b1, 32'h40, 2'b01, 1'b0, 32'hDEADBEEF);
    chk("half_st_b0", 32'(ram_val(9'h040)), 32'hEF);
    chk("half_st_b1", 32'(ram_val(9'h041)), 32'hBE);
    run_req(1'b0, 32'h41, 2'b01, 1'b1, 32'h0);
    run_req(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0);
    run_req(1'b0, 32'hFFFFFFFE, 2'b11, 1'b1, 32'h0);
    run_req(1'b0, 32'h102, 2'b10, 1'b0, 32'h0);
    run_req(1'b1, 32'h103, 2'b01, 1'b0, 32'hCAFEF00D);

    // Reset asserted during cycle 2 of a word store.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h80;
    req_width = 2'b10;
    req_sign  = 1'b0;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wr_c1", 32'(ram_wr), 32'd1);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_wr_off", 32'(ram_wr), 32'd0);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_addr", ram_addr, 32'h0);
    ref_mem[9'h080] = 8'hD4;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(resp_valid), 32'd0);
    end
    chk("abort_b0", 32'(ram_val(9'h080)), 32'hD4);
    chk("abort_b1", 32'(ram_val(9'h081)), 32'(ref_mem[9'h081]));
    run_req(1'b0, 32'h80, 2'b10, 1'b0, 32'h0);

    // Random traffic, including addresses near the top of the 32-bit space.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFE00 | 32'($urandom_range(0, 511));
      else                           addr = 32'($urandom_range(0, 511));
      run_req(1'($urandom), addr, 2'($urandom), 1'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of ram_addr; byte addresses truncated to ADDR_W LSBs.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request from MEM stage.
REQ-005 SHALL have port req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we  input  1  1 store, 0 load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_width  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port req_sign  input  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 SHALL have port req_wdata  input  32  store data, low N bytes used.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse (load and store).
REQ-012 SHALL have port resp_rdata  output  32  extended load data; held until next resp_valid; 0 for stores.
REQ-013 SHALL have port resp_err  output  1  misalignment flag, qualified by resp_valid.
REQ-014 SHALL have ports ram_addr  output  ADDR_W; ram_wr  output  1; ram_dout  output  8; ram_din  input  8  byte RAM, read data valid the cycle after ram_addr.

Function
REQ-015 SHALL use FSM states IDLE, RD, RD_LAST, WR, RESP.
REQ-016 SHALL capture all req_* fields at acceptance (cycle 0); later req_* changes ignored until back in IDLE.
REQ-017 SHALL access N bytes (N = 1/2/4 per width), little-endian, byte k at req_addr+k, address addition wrapping modulo 2^32.
REQ-018 Load: SHALL drive ram_addr for byte k in cycle k+1 (state RD, last byte RD_LAST), sample ram_din for byte k in cycle k+2, pulse resp_valid in cycle N+2.
REQ-019 Store: SHALL drive ram_wr=1, ram_addr=addr+k, ram_dout=byte k in cycle k+1 (state WR), pulse resp_valid in cycle N+1.
REQ-020 SHALL hold ram_wr=0 in every state except WR.
REQ-021 SHALL return to IDLE the cycle after resp_valid; req_ready high again that cycle; back-to-back requests thus separated by one cycle of RESP.
REQ-022 SHALL produce resp_rdata via extension: byte/half MSB replicated when req_sign=1, zeros otherwise; word unchanged.
REQ-023 SHALL keep ram_addr at its last value when idle (no spurious ram_wr).
REQ-024 SHALL drive resp_err=0 except per REQ-029.

Reset
REQ-025 On rst low, asynchronously: state IDLE, req_ready=1 once released, resp_valid=0, resp_err=0, resp_rdata=0, ram_wr=0, ram_addr=0, ram_dout=0.
REQ-026 Reset mid-operation SHALL abort the transfer; no resp_valid for the aborted request; partial store bytes already written remain.
REQ-027 First acceptance possible on the first rising edge with rst high.

Configuration
REQ-028 Macro MEM_CTRL_MISALIGN_CHK_EN SHALL select misalignment checking.
REQ-029 With it defined: half at odd address or word with addr[1:0]!=0 SHALL perform no RAM access and pulse resp_valid with resp_err=1, resp_rdata=0 in cycle 1.
REQ-030 Without it: resp_err tied 0; misaligned accesses performed bytewise per REQ-017.

Structure
REQ-031 Width encodings, FSM state encodings, ZERO_WORD and word/address length constants SHALL live in the shared defines package.
REQ-032 Extension logic SHALL be one combinational sub-module, load_ext (inputs: 32-bit raw, width, sign).

Verification
REQ-033 Word load addr 0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_addr 0x100..0x103 cycles 1-4, resp_valid cycle 6, rdata 0x44332211.
REQ-034 Byte load addr 0x20, RAM=0x80, sign=1 -> rdata 0xFFFFFF80; sign=0 -> 0x00000080; resp_valid cycle 3.
REQ-035 Half store addr 0x40 wdata 0xDEADBEEF -> ram_wr cycles 1-2, bytes EF@0x40, BE@0x41, resp_valid cycle 3, no write cycle 4.
REQ-036 Word load addr 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 (ADDR_W=32).
REQ-037 rst low in cycle 2 of word store -> ram_wr 0 immediately, no resp_valid, next request accepted normally.
REQ-038 With MEM_CTRL_MISALIGN_CHK_EN: word load addr 0x102 -> no ram access, resp_valid+resp_err cycle 1, rdata 0; without macro -> normal 4-byte access.
